// File: rtl/counter_axil_if.sv
// AXI4-Lite slave bus bundle for the seconds-counter register bank.
// The slave modport is used by counter_axil_regs and the master modport by the PS side.
interface counter_axil_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] s_axil_awaddr;
    logic                  s_axil_awvalid;
    logic                  s_axil_awready;
    logic [31:0]           s_axil_wdata;
    logic [3:0]            s_axil_wstrb;
    logic                  s_axil_wvalid;
    logic                  s_axil_wready;
    logic [1:0]            s_axil_bresp;
    logic                  s_axil_bvalid;
    logic                  s_axil_bready;
    logic [ADDR_WIDTH-1:0] s_axil_araddr;
    logic                  s_axil_arvalid;
    logic                  s_axil_arready;
    logic [31:0]           s_axil_rdata;
    logic [1:0]            s_axil_rresp;
    logic                  s_axil_rvalid;
    logic                  s_axil_rready;

    modport slave (
        input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
               s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
        output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
               s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
    );

    modport master (
        output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
               s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready,
        input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
               s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
    );
endinterface

// File: rtl/counter_axil_regs.sv
// AXI4-Lite register bank for the 1 Hz seconds counter: CTRL/enable word, count
// readback, sticky change-detect status with maskable level interrupt.
module counter_axil_regs #(
    parameter int          ADDR_WIDTH    = 5,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    counter_axil_if.slave         bus,
    output logic [31:0]           enable,
    input  logic [31:0]           count,
    output logic                  irq
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam logic [IW-1:0] IDX_CTRL    = IW'(0);
    localparam logic [IW-1:0] IDX_COUNT   = IW'(1);
    localparam logic [IW-1:0] IDX_STATUS  = IW'(2);
    localparam logic [IW-1:0] IDX_IRQ_EN  = IW'(3);
    localparam logic [IW-1:0] IDX_SCRATCH = IW'(4);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    w_state_t        w_state_r;
    r_state_t        r_state_r;
    logic            awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [1:0]      bresp_r, rresp_r;
    logic [31:0]     rdata_r;
    logic [IW-1:0]   awidx_r;
    logic [31:0]     wdata_r;
    logic [3:0]      wstrb_r;
    logic [31:0]     ctrl_r, scratch_r, count_d_r;
    logic            chg_r, irq_en_r, prim_r, irq_r;

    logic            aw_hs_s, w_hs_s, ar_hs_s, wr_fire_s, chg_set_s, chg_clr_s;
    logic [IW-1:0]   wr_idx_s, rd_idx_s;
    logic [31:0]     wr_data_s, rd_data_s, status_s;
    logic [3:0]      wr_strb_s;
    logic [1:0]      rd_resp_s;
    logic            unused_addr_bits_s;

    // Handshake qualification, write operand selection, change detect and read mux.
    always_comb begin
        aw_hs_s  = bus.s_axil_awvalid & awready_r;
        w_hs_s   = bus.s_axil_wvalid & wready_r;
        ar_hs_s  = bus.s_axil_arvalid & arready_r;
        if (awready_r) begin
            wr_idx_s = bus.s_axil_awaddr[ADDR_WIDTH-1:2];
        end else begin
            wr_idx_s = awidx_r;
        end
        if (wready_r) begin
            wr_data_s = bus.s_axil_wdata;
            wr_strb_s = bus.s_axil_wstrb;
        end else begin
            wr_data_s = wdata_r;
            wr_strb_s = wstrb_r;
        end
        // In W_IDLE a dropped ready means that channel's beat is already held.
        wr_fire_s = (w_state_r == W_IDLE) && (!awready_r || aw_hs_s) && (!wready_r || w_hs_s);
        chg_set_s = prim_r && (count != count_d_r);
        chg_clr_s = wr_fire_s && (wr_idx_s == IDX_STATUS) && wr_strb_s[0] && wr_data_s[0];
        status_s  = {30'b0, (ctrl_r != 32'h0000_0000), chg_r};
        rd_idx_s  = bus.s_axil_araddr[ADDR_WIDTH-1:2];
        rd_resp_s = RESP_OKAY;
        case (rd_idx_s)
            IDX_CTRL:    rd_data_s = ctrl_r;
            IDX_COUNT:   rd_data_s = count;
            IDX_STATUS:  rd_data_s = status_s;
            IDX_IRQ_EN:  rd_data_s = {31'b0, irq_en_r};
            IDX_SCRATCH: rd_data_s = scratch_r;
            default: begin
                rd_data_s = 32'h0000_0000;
                rd_resp_s = RESP_SLVERR;
            end
        endcase
        unused_addr_bits_s = ^{bus.s_axil_awaddr[1:0], bus.s_axil_araddr[1:0]};
    end

    // Write channel FSM: independent AW/W capture, execute when both present, hold B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            awidx_r   <= '0;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'h0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (wr_fire_s) begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        bvalid_r  <= 1'b1;
                        bresp_r   <= (wr_idx_s <= IDX_SCRATCH) ? RESP_OKAY : RESP_SLVERR;
                        w_state_r <= W_RESP;
                    end else begin
                        if (aw_hs_s) begin
                            awidx_r   <= bus.s_axil_awaddr[ADDR_WIDTH-1:2];
                            awready_r <= 1'b0;
                        end
                        if (w_hs_s) begin
                            wdata_r  <= bus.s_axil_wdata;
                            wstrb_r  <= bus.s_axil_wstrb;
                            wready_r <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.s_axil_bready) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    bvalid_r  <= 1'b0;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b1;
                end
            endcase
        end
    end

    // Read channel FSM: register data on the AR handshake and hold it until rready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rdata_r   <= rd_data_s;
                        rresp_r   <= rd_resp_s;
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        r_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.s_axil_rready) begin
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                        r_state_r <= R_IDLE;
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    rvalid_r  <= 1'b0;
                    arready_r <= 1'b1;
                end
            endcase
        end
    end

    // Register storage, change detection with set-over-clear priority, and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r    <= 32'h0000_0000;
            scratch_r <= SCRATCH_RESET;
            irq_en_r  <= 1'b0;
            chg_r     <= 1'b0;
            prim_r    <= 1'b0;
            count_d_r <= 32'h0000_0000;
            irq_r     <= 1'b0;
        end else begin
            if (wr_fire_s) begin
                case (wr_idx_s)
                    IDX_CTRL:    ctrl_r    <= apply_strb(ctrl_r, wr_data_s, wr_strb_s);
                    IDX_IRQ_EN:  irq_en_r  <= wr_strb_s[0] ? wr_data_s[0] : irq_en_r;
                    IDX_SCRATCH: scratch_r <= apply_strb(scratch_r, wr_data_s, wr_strb_s);
                    default: ;
                endcase
            end
            count_d_r <= count;
            prim_r    <= 1'b1;
            if (chg_set_s) begin
                chg_r <= 1'b1;
            end else if (chg_clr_s) begin
                chg_r <= 1'b0;
            end
            irq_r <= chg_r & irq_en_r;
        end
    end

    assign bus.s_axil_awready = awready_r;
    assign bus.s_axil_wready  = wready_r;
    assign bus.s_axil_bvalid  = bvalid_r;
    assign bus.s_axil_bresp   = bresp_r;
    assign bus.s_axil_arready = arready_r;
    assign bus.s_axil_rvalid  = rvalid_r;
    assign bus.s_axil_rdata   = rdata_r;
    assign bus.s_axil_rresp   = rresp_r;
    assign enable             = ctrl_r;
    assign irq                = irq_r;
endmodule

// File: tb/tb_counter_axil_regs.sv
// Directed self-checking bench for counter_axil_regs: reset, write/read paths,
// strobes, backpressure, change-detect interrupt, unmapped decode.
module tb_counter_axil_regs;
    localparam logic [31:0] SCR_RST = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] enable;
    logic [31:0] count;
    logic        irq;
    int          checks;
    int          errors;

    counter_axil_if #(.ADDR_WIDTH(5)) bus ();

    counter_axil_regs #(.ADDR_WIDTH(5), .SCRATCH_RESET(SCR_RST)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .enable (enable),
        .count  (count),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, aw_rdy, w_rdy;
        int   n;
        aw_done = 1'b0; w_done = 1'b0; resp = 2'b11;
        bus.s_axil_awaddr = addr; bus.s_axil_wdata = data; bus.s_axil_wstrb = strb;
        bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1; bus.s_axil_bready = 1'b1;
        n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_rdy = bus.s_axil_awready; w_rdy = bus.s_axil_wready;
            @(posedge clk); #1;
            if (aw_rdy && bus.s_axil_awvalid) begin aw_done = 1'b1; bus.s_axil_awvalid = 1'b0; end
            if (w_rdy && bus.s_axil_wvalid) begin w_done = 1'b1; bus.s_axil_wvalid = 1'b0; end
            n++;
        end
        n = 0;
        while (!bus.s_axil_bvalid && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (!bus.s_axil_bvalid) begin
            errors++;
            $display("FAIL write_timeout addr=%h: bvalid=%b, required 1", addr, bus.s_axil_bvalid);
            bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;
        end else begin
            resp = bus.s_axil_bresp;
        end
        @(posedge clk); #1;
        bus.s_axil_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic ar_rdy;
        int   n;
        data = 32'hFFFF_FFFF; resp = 2'b11;
        bus.s_axil_araddr = addr; bus.s_axil_arvalid = 1'b1; bus.s_axil_rready = 1'b1;
        n = 0;
        while (bus.s_axil_arvalid && n < 50) begin
            ar_rdy = bus.s_axil_arready;
            @(posedge clk); #1;
            if (ar_rdy) bus.s_axil_arvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!bus.s_axil_rvalid && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (!bus.s_axil_rvalid) begin
            errors++;
            $display("FAIL read_timeout addr=%h: rvalid=%b, required 1", addr, bus.s_axil_rvalid);
            bus.s_axil_arvalid = 1'b0;
        end else begin
            data = bus.s_axil_rdata; resp = bus.s_axil_rresp;
        end
        @(posedge clk); #1;
        bus.s_axil_rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        checks++;
        if ({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready, bus.s_axil_bvalid,
             bus.s_axil_rvalid, irq} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_handshake: got %b, required 111000", {bus.s_axil_awready,
                     bus.s_axil_wready, bus.s_axil_arready, bus.s_axil_bvalid, bus.s_axil_rvalid, irq});
        end
        checks++;
        if (enable !== 32'h0 || bus.s_axil_rdata !== 32'h0 || bus.s_axil_bresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_values: enable=%h rdata=%h bresp=%b, required 0", enable,
                     bus.s_axil_rdata, bus.s_axil_bresp);
        end
        bus.s_axil_awaddr = 5'h00; bus.s_axil_awvalid = 1'b1;
        bus.s_axil_wdata = 32'h0000_0055; bus.s_axil_wstrb = 4'hF;
        @(posedge clk); #1;
        bus.s_axil_awvalid = 1'b0;
        checks++;
        if (bus.s_axil_awready !== 1'b0) begin
            errors++;
            $display("FAIL aw_captured: awready=%b, required 0", bus.s_axil_awready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (enable !== 32'h0 || bus.s_axil_bvalid !== 1'b0 || bus.s_axil_awready !== 1'b1) begin
            errors++;
            $display("FAIL mid_write_reset: enable=%h bvalid=%b awready=%b, required 0/0/1",
                     enable, bus.s_axil_bvalid, bus.s_axil_awready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        axi_read(5'h00, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: got %h/%b, required 00000000/00", d, r);
        end
        axi_read(5'h10, d, r);
        checks++;
        if (d !== SCR_RST) begin
            errors++;
            $display("FAIL reset_scratch: got %h, required %h", d, SCR_RST);
        end
    endtask

    task automatic test_ctrl_w_first();
        logic [31:0] d;
        logic [1:0]  r;
        bus.s_axil_awaddr = 5'h00; bus.s_axil_wdata = 32'h0000_0001; bus.s_axil_wstrb = 4'hF;
        bus.s_axil_wvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_axil_wvalid = 1'b0;
        checks++;
        if (bus.s_axil_wready !== 1'b0 || bus.s_axil_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL w_captured: wready=%b bvalid=%b, required 0/0", bus.s_axil_wready,
                     bus.s_axil_bvalid);
        end
        repeat (2) @(posedge clk);
        #1 bus.s_axil_awvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_axil_awvalid = 1'b0;
        checks++;
        if (bus.s_axil_bvalid !== 1'b1 || bus.s_axil_bresp !== 2'b00 || enable !== 32'h1) begin
            errors++;
            $display("FAIL ctrl_write_latency: bvalid=%b bresp=%b enable=%h, required 1/00/00000001",
                     bus.s_axil_bvalid, bus.s_axil_bresp, enable);
        end
        bus.s_axil_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_axil_bready = 1'b0;
        checks++;
        if (bus.s_axil_bvalid !== 1'b0 || bus.s_axil_awready !== 1'b1 || bus.s_axil_wready !== 1'b1) begin
            errors++;
            $display("FAIL b_complete: bvalid=%b awready=%b wready=%b, required 0/1/1",
                     bus.s_axil_bvalid, bus.s_axil_awready, bus.s_axil_wready);
        end
        axi_read(5'h08, d, r);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL status_running: got %h, required 00000002", d);
        end
    endtask

    task automatic test_strobe_backpressure();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h10, 32'hA5A5_A5A5, 4'hF, r);
        bus.s_axil_awaddr = 5'h10; bus.s_axil_wdata = 32'h1234_5678; bus.s_axil_wstrb = 4'b0010;
        bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1; bus.s_axil_bready = 1'b0;
        @(posedge clk); #1;
        bus.s_axil_wdata = 32'hDEAD_BEEF; bus.s_axil_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.s_axil_bvalid !== 1'b1 || bus.s_axil_awready !== 1'b0 || bus.s_axil_wready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: bvalid=%b awready=%b wready=%b, required 1/0/0", i,
                         bus.s_axil_bvalid, bus.s_axil_awready, bus.s_axil_wready);
            end
            @(posedge clk); #1;
        end
        bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0; bus.s_axil_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_axil_bready = 1'b0;
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'hA5A5_56A5) begin
            errors++;
            $display("FAIL scratch_strobe: got %h, required a5a556a5", d);
        end
    endtask

    task automatic test_change_irq();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h0C, 32'h1, 4'hF, r);
        count = 32'h7;
        repeat (2) @(posedge clk);
        #1;
        axi_write(5'h08, 32'h1, 4'hF, r);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared_pre: irq=%b, required 0", irq); end
        count = 32'h8;
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_not_early: irq=%b, required 0", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: irq=%b, required 1", irq); end
        bus.s_axil_awaddr = 5'h08; bus.s_axil_wdata = 32'h1; bus.s_axil_wstrb = 4'hF;
        bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1; count = 32'h9;
        @(posedge clk); #1;
        bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0; bus.s_axil_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_axil_bready = 1'b0;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq: irq=%b, required 1", irq); end
        axi_read(5'h08, d, r);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL set_wins_status: got %h, required 00000003", d); end
        axi_write(5'h08, 32'h1, 4'hF, r);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: irq=%b, required 0", irq); end
        axi_write(5'h0C, 32'h0, 4'hF, r);
        count = 32'hA;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: irq=%b, required 0", irq); end
        axi_read(5'h08, d, r);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL masked_status: got %h, required 00000003", d); end
        axi_write(5'h08, 32'h1, 4'h1, r);
        axi_read(5'h08, d, r);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL status_cleared: got %h, required 00000002", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(5'h18, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++;
            $display("FAIL unmapped_read: got %h/%b, required 00000000/10", d, r);
        end
        axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL unmapped_bresp: got %b, required 10", r); end
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL count_write_bresp: got %b, required 00", r); end
        axi_read(5'h00, d, r);
        checks++;
        if (d !== 32'h1 || enable !== 32'h1) begin
            errors++;
            $display("FAIL unmapped_ctrl: got %h enable=%h, required 00000001", d, enable);
        end
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'hA5A5_56A5) begin errors++; $display("FAIL unmapped_scratch: got %h, required a5a556a5", d); end
        axi_read(5'h0C, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_irq_en: got %h, required 00000000", d); end
        axi_read(5'h04, d, r);
        checks++;
        if (d !== 32'hA || r !== 2'b00) begin
            errors++;
            $display("FAIL count_read: got %h/%b, required 0000000a/00", d, r);
        end
    endtask

    task automatic test_read_hold();
        count = 32'h0000_00FF;
        bus.s_axil_araddr = 5'h04; bus.s_axil_arvalid = 1'b1; bus.s_axil_rready = 1'b0;
        @(posedge clk); #1;
        bus.s_axil_arvalid = 1'b0;
        count = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.s_axil_rvalid !== 1'b1 || bus.s_axil_rdata !== 32'hFF || bus.s_axil_arready !== 1'b0) begin
                errors++;
                $display("FAIL read_hold cyc%0d: rvalid=%b rdata=%h arready=%b, required 1/000000ff/0",
                         i, bus.s_axil_rvalid, bus.s_axil_rdata, bus.s_axil_arready);
            end
            @(posedge clk); #1;
        end
        bus.s_axil_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_axil_rready = 1'b0;
        checks++;
        if (bus.s_axil_rvalid !== 1'b0 || bus.s_axil_arready !== 1'b1) begin
            errors++;
            $display("FAIL read_complete: rvalid=%b arready=%b, required 0/1", bus.s_axil_rvalid,
                     bus.s_axil_arready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        bus.s_axil_araddr = 5'h10; bus.s_axil_arvalid = 1'b1; bus.s_axil_rready = 1'b0;
        bus.s_axil_awaddr = 5'h10; bus.s_axil_wdata = 32'h0BAD_F00D; bus.s_axil_wstrb = 4'hF;
        bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1; bus.s_axil_bready = 1'b0;
        @(posedge clk); #1;
        bus.s_axil_arvalid = 1'b0; bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;
        checks++;
        if (bus.s_axil_rvalid !== 1'b1 || bus.s_axil_rdata !== 32'hA5A5_56A5 || bus.s_axil_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL rw_same_cycle: rvalid=%b rdata=%h bvalid=%b, required 1/a5a556a5/1",
                     bus.s_axil_rvalid, bus.s_axil_rdata, bus.s_axil_bvalid);
        end
        bus.s_axil_rready = 1'b1; bus.s_axil_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_axil_rready = 1'b0; bus.s_axil_bready = 1'b0;
        axi_write(5'h00, 32'h0000_0000, 4'hF, r);
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h0BAD_F00D) begin errors++; $display("FAIL rw_post_write: got %h, required 0badf00d", d); end
        axi_read(5'h08, d, r);
        checks++;
        if (d[1] !== 1'b0 || enable !== 32'h0) begin
            errors++;
            $display("FAIL running_off: status=%h enable=%h, required bit1=0/00000000", d, enable);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; count = 32'h0;
        bus.s_axil_awaddr = 5'h0; bus.s_axil_awvalid = 1'b0; bus.s_axil_wdata = 32'h0;
        bus.s_axil_wstrb = 4'h0; bus.s_axil_wvalid = 1'b0; bus.s_axil_bready = 1'b0;
        bus.s_axil_araddr = 5'h0; bus.s_axil_arvalid = 1'b0; bus.s_axil_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_ctrl_w_first();
        test_strobe_backpressure();
        test_change_irq();
        test_unmapped();
        test_read_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
